ll_stream_encoder: RTL
======================

Name: ll_stream_encoder

Overview:
Streaming line-length (LL) window encoder, successor to the buffered LL encoder. It accumulates per-channel LL incrementally from incoming samples without a full window sample memory, and supports overlapping windows (any WINDOW_STEP dividing WINDOW_SIZE). Each LL is quantised, bound with its channel HV and majority-bundled over a run-time channel mask. The resulting window HV is offered on a valid/ready output, with sticky overrun reporting. It feeds the associative-memory/classifier stage.

Parameters:
DIMENSIONS, 10000, HV width
NUM_CHS, 17, channel count
SAMPLE_SIZE, 16, signed two's-complement sample width
WINDOW_SIZE, 256, samples per window
WINDOW_STEP, 128, samples between window starts; WINDOW_SIZE % WINDOW_STEP == 0
NUM_LL, 64, number of quantised LL levels
LL_SHIFT, 6, right shift applied to raw LL before saturation
K (derived), WINDOW_SIZE/WINDOW_STEP, segments per window
LL_WIDTH (derived), SAMPLE_SIZE+1+$clog2(WINDOW_SIZE), raw LL width

Ports:
clk  in  1  clock, rising edge
nrst  in  1  asynchronous active-low reset
sample_valid  in  1  one sample per channel present this cycle
samples  in  NUM_CHS x SAMPLE_SIZE  signed samples, channel-indexed
ch_mask  in  NUM_CHS  1 = channel participates in bundling
window_ready  in  1  downstream accepts window_hv
clear_overrun  in  1  clears overrun
window_valid  out  1  window_hv valid, held until accepted
window_hv  out  DIMENSIONS  encoded window HV
busy  out  1  encode in progress or output pending
overrun  out  1  sticky: a completed window was dropped

Behaviour:
- Reset (async, nrst=0): window_valid=0, window_hv=0, busy=0, overrun=0. Segment sums, sample counter, previous samples, snapshot, counters and FSM all clear. The first window after reset requires a full WINDOW_SIZE samples.
- Diff: |x[n]-x[n-1]| computed in SAMPLE_SIZE+1 unsigned bits, no overflow; the first sample after reset contributes 0.
- Per channel: K segment sums, ring-indexed. The current segment accumulates diffs of WINDOW_STEP samples. At segment wrap, the oldest segment is reused (zeroed before its first add).
- Window completion is the sample_valid cycle carrying sample index WINDOW_SIZE-1 (first window), then every WINDOW_STEP samples. On completion, raw LL = sum of K segment sums including the current sample's diff. Each channel's raw LL is snapshotted with ch_mask on the next edge; accumulation continues unaffected.
- Level = min(rawLL >> LL_SHIFT, NUM_LL-1).
- FSM IDLE -> ENC -> MAJ -> OUT -> IDLE:
  - IDLE: a completion enters ENC with c=0, clears bundle counters, busy=1.
  - ENC: one channel per cycle. bound = ch_hv[c] XOR level_hv[level[c]]; if mask bit set, per-bit counter += bound bit. After c=NUM_CHS-1 go to MAJ.
  - MAJ: bit i = (2*count_i > active), active = popcount(snapshot mask); ties resolve to 0; active=0 gives all-zero HV. Load window_hv, set window_valid, go to OUT.
  - OUT: hold until window_valid && window_ready, then window_valid=0 and return to IDLE. busy deasserts on the same edge unless another window is already pending.
- Latency: completion cycle t -> window_valid high from cycle t+NUM_CHS+2.
- Overlap: a completion arriving while in ENC/MAJ/OUT is dropped, its snapshot is not taken, and overrun is set. Acceptance and a new completion on the same cycle: the new window is accepted (no overrun).
- overrun stays set until clear_overrun; a set and a clear on the same cycle leaves it set.
- sample_valid=0 cycles: no state change in the accumulator.
- Counter width: $clog2(NUM_CHS+1).

Decomposition:
- Shared package: LL_WIDTH/K derivation, level type [$clog2(NUM_LL)-1:0], FSM enum.
- Sub-module ll_seg_accum: previous-sample register, diff, segment ring, window completion pulse and raw LL vector, one instance covering all channels.
- Reuse the team's channel/level item memory and XOR binder.

Test Plan:
Use small parameters unless stated: NUM_CHS=4, DIMENSIONS=64, WINDOW_SIZE=8, WINDOW_STEP=4, LL_SHIFT=2, NUM_LL=8, all mask bits 1.
1. Constant samples 5 for 8 valids -> level 0 on every channel; window_valid at t+6; hv = bitwise majority (ties->0) of ch_hv[c]^level_hv[0].
2. ch0 alternates 0,1 -> first window raw 7, level 1; second window (after 4 more samples) raw 8, level 2; other channels level 0.
3. ch0 samples -32768, 32767 alternating with SAMPLE_SIZE=16 -> diff 65535, level saturates at 7.
4. Hold window_ready=0 across two completions -> first window held stable, second dropped, overrun=1. Pulse clear_overrun -> overrun=0.
5. ch_mask=0 -> window_hv all zero. ch_mask=0001 -> hv = ch_hv[0]^level_hv[level0].
6. Drop nrst during ENC -> all outputs 0 immediately; the next window appears only after 8 fresh valids.

Source files
------------

// File: rtl/ll_stream_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ll_stream_encoder_pkg
// Description : Shared definitions for the streaming line-length encoder:
//               derived-width helpers, encoder FSM state type, item-memory
//               seeds and the item-memory bit generator.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ll_stream_encoder_pkg;

  // Seeds of the channel and level item memories.
  localparam logic [31:0] SEED_CH  = 32'h1234_5678;
  localparam logic [31:0] SEED_LVL = 32'h9ABC_DEF0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_MAJ  = 2'd2,
    ST_OUT  = 2'd3
  } enc_state_e;

  // Raw line-length width: one diff is SAMPLE_SIZE+1 bits, a window sums
  // WINDOW_SIZE of them.
  function automatic int ll_width(input int sample_size, input int window_size);
    return sample_size + 1 + $clog2(window_size);
  endfunction

  // Segments per window.
  function automatic int seg_count(input int window_size, input int window_step);
    return window_size / window_step;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Level register width for a given number of quantised levels.
  function automatic int level_width(input int num_ll);
    return safe_clog2(num_ll);
  endfunction

  // Pseudo-random item-memory bit: a 32-bit integer mix of (seed, item, bit).
  // Every item vector is fixed at build time and identical across instances.
  function automatic logic im_bit(input logic [31:0] seed, input logic [31:0] idx,
                                  input logic [31:0] pos);
    logic [31:0] h;
    h = seed ^ (idx * 32'h9E37_79B1) ^ (pos * 32'h85EB_CA77);
    h = h ^ (h >> 16);
    h = h * 32'h7FEB_352D;
    h = h ^ (h >> 15);
    h = h * 32'h846C_A68B;
    h = h ^ (h >> 16);
    return h[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ll_stream_encoder_seg_accum.sv
`default_nettype none
// ============================================================================
// Module      : ll_seg_accum
// Description : Incremental per-channel line-length accumulator. Keeps the
//               previous sample, computes |x[n]-x[n-1]| and adds it into a
//               ring of K segment sums. Flags window completion and presents
//               the raw line length of every channel on that same cycle.
// Ports       : clk        - clock, rising edge
//               nrst       - asynchronous active-low reset
//               i_valid    - one sample per channel this cycle
//               i_samples  - signed samples, channel-indexed
//               o_done     - window completes with this cycle's sample
//               o_raw_ll   - raw LL per channel (valid when o_done)
// Revision    : 1.0 - initial release
// ============================================================================
module ll_seg_accum
  import ll_stream_encoder_pkg::*;
#(
  parameter int NUM_CHS     = 17,
  parameter int SAMPLE_SIZE = 16,
  parameter int WINDOW_SIZE = 256,
  parameter int WINDOW_STEP = 128,
  parameter int LL_WIDTH    = ll_width(SAMPLE_SIZE, WINDOW_SIZE)
) (
  input  logic                                  clk,
  input  logic                                  nrst,
  input  logic                                  i_valid,
  input  logic [NUM_CHS-1:0][SAMPLE_SIZE-1:0]   i_samples,
  output logic                                  o_done,
  output logic [NUM_CHS-1:0][LL_WIDTH-1:0]      o_raw_ll
);

  localparam int K      = seg_count(WINDOW_SIZE, WINDOW_STEP);
  localparam int DIFF_W = SAMPLE_SIZE + 1;
  localparam int SEG_W  = DIFF_W + $clog2(WINDOW_STEP);
  localparam int POS_W  = safe_clog2(WINDOW_STEP);
  localparam int PTR_W  = safe_clog2(K);

  logic [NUM_CHS-1:0][SAMPLE_SIZE-1:0] r_prev;
  logic                                r_have_prev;
  logic [SEG_W-1:0]                    r_seg [NUM_CHS][K];
  logic [POS_W-1:0]                    r_pos;   // sample position inside segment
  logic [PTR_W-1:0]                    r_ptr;   // segment currently accumulating
  logic [PTR_W-1:0]                    r_seen;  // completed segments, saturates at K-1

  logic                                w_seg_first;
  logic                                w_seg_last;
  logic signed [DIFF_W:0]              w_delta [NUM_CHS];
  logic [DIFF_W-1:0]                   w_diff  [NUM_CHS];
  logic [SEG_W-1:0]                    w_cur   [NUM_CHS];

  assign w_seg_first = (r_pos == '0);
  assign w_seg_last  = (r_pos == POS_W'(WINDOW_STEP - 1));

  // The first window needs K full segments; afterwards every segment end
  // closes a window.
  assign o_done = i_valid && w_seg_last && (r_seen == PTR_W'(K - 1));

  always_comb begin
    for (int c = 0; c < NUM_CHS; c++) begin
      // Two guard bits: the signed difference spans +/-(2^SAMPLE_SIZE - 1).
      w_delta[c] = $signed({i_samples[c][SAMPLE_SIZE-1], i_samples[c][SAMPLE_SIZE-1], i_samples[c]})
                 - $signed({r_prev[c][SAMPLE_SIZE-1], r_prev[c][SAMPLE_SIZE-1], r_prev[c]});
      if (!r_have_prev) begin
        w_diff[c] = '0;
      end else if (w_delta[c][DIFF_W]) begin
        w_diff[c] = DIFF_W'(-w_delta[c]);
      end else begin
        w_diff[c] = w_delta[c][DIFF_W-1:0];
      end

      // A reused ring slot restarts from the diff instead of adding to stale data.
      w_cur[c] = w_seg_first ? SEG_W'(w_diff[c]) : (r_seg[c][r_ptr] + SEG_W'(w_diff[c]));

      o_raw_ll[c] = LL_WIDTH'(w_cur[c]);
      for (int k = 0; k < K; k++) begin
        if (PTR_W'(k) != r_ptr) begin
          o_raw_ll[c] = o_raw_ll[c] + LL_WIDTH'(r_seg[c][k]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_pos       <= '0;
      r_ptr       <= '0;
      r_seen      <= '0;
      for (int c = 0; c < NUM_CHS; c++) begin
        for (int k = 0; k < K; k++) begin
          r_seg[c][k] <= '0;
        end
      end
    end else if (i_valid) begin
      r_prev      <= i_samples;
      r_have_prev <= 1'b1;
      for (int c = 0; c < NUM_CHS; c++) begin
        r_seg[c][r_ptr] <= w_cur[c];
      end
      if (w_seg_last) begin
        r_pos <= '0;
        r_ptr <= (r_ptr == PTR_W'(K - 1)) ? '0 : (r_ptr + PTR_W'(1));
        if (r_seen != PTR_W'(K - 1)) begin
          r_seen <= r_seen + PTR_W'(1);
        end
      end else begin
        r_pos <= r_pos + POS_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ll_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module      : ll_stream_encoder
// Description : Streaming line-length window encoder. Raw LL per channel is
//               quantised to a level, bound (XOR) with the channel HV and
//               majority-bundled over the snapshotted channel mask. The window
//               HV is offered on a valid/ready output; windows that complete
//               while the encoder is occupied are dropped and flagged.
// Ports       : clk           - clock, rising edge
//               nrst          - asynchronous active-low reset
//               sample_valid  - one sample per channel this cycle
//               samples       - signed samples, channel-indexed
//               ch_mask       - 1 = channel participates in bundling
//               window_ready  - downstream accepts window_hv
//               clear_overrun - clears overrun
//               window_valid  - window_hv valid, held until accepted
//               window_hv     - encoded window HV
//               busy          - encode in progress or output pending
//               overrun       - sticky: a completed window was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module ll_stream_encoder
  import ll_stream_encoder_pkg::*;
#(
  parameter int DIMENSIONS  = 10000,
  parameter int NUM_CHS     = 17,
  parameter int SAMPLE_SIZE = 16,
  parameter int WINDOW_SIZE = 256,
  parameter int WINDOW_STEP = 128,
  parameter int NUM_LL      = 64,
  parameter int LL_SHIFT    = 6
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic                                sample_valid,
  input  logic [NUM_CHS-1:0][SAMPLE_SIZE-1:0] samples,
  input  logic [NUM_CHS-1:0]                  ch_mask,
  input  logic                                window_ready,
  input  logic                                clear_overrun,
  output logic                                window_valid,
  output logic [DIMENSIONS-1:0]               window_hv,
  output logic                                busy,
  output logic                                overrun
);

  localparam int LL_WIDTH = ll_width(SAMPLE_SIZE, WINDOW_SIZE);
  localparam int LVL_W    = level_width(NUM_LL);
  localparam int CNT_W    = $clog2(NUM_CHS + 1);
  localparam int CH_W     = safe_clog2(NUM_CHS);

  // --------------------------------------------------------------------------
  // Item memories: fixed pseudo-random HVs per channel and per level.
  // --------------------------------------------------------------------------
  function automatic logic [DIMENSIONS-1:0] im_vec(input logic [31:0] seed, input int idx);
    logic [DIMENSIONS-1:0] v;
    for (int i = 0; i < DIMENSIONS; i++) begin
      v[i] = im_bit(seed, 32'(idx), 32'(i));
    end
    return v;
  endfunction

  function automatic logic [CNT_W-1:0] popcnt(input logic [NUM_CHS-1:0] m);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CHS; i++) begin
      n = n + CNT_W'(m[i]);
    end
    return n;
  endfunction

  logic [DIMENSIONS-1:0] w_ch_hv  [NUM_CHS];
  logic [DIMENSIONS-1:0] w_lvl_hv [NUM_LL];

  for (genvar c = 0; c < NUM_CHS; c++) begin : g_ch_im
    assign w_ch_hv[c] = im_vec(SEED_CH, c);
  end

  for (genvar l = 0; l < NUM_LL; l++) begin : g_lvl_im
    assign w_lvl_hv[l] = im_vec(SEED_LVL, l);
  end

  // --------------------------------------------------------------------------
  // Line-length accumulation and quantisation
  // --------------------------------------------------------------------------
  logic                              w_done;
  logic [NUM_CHS-1:0][LL_WIDTH-1:0]  w_raw_ll;
  logic [LL_WIDTH-1:0]               w_shifted [NUM_CHS];
  logic [LVL_W-1:0]                  w_level   [NUM_CHS];

  ll_seg_accum #(
    .NUM_CHS     (NUM_CHS),
    .SAMPLE_SIZE (SAMPLE_SIZE),
    .WINDOW_SIZE (WINDOW_SIZE),
    .WINDOW_STEP (WINDOW_STEP),
    .LL_WIDTH    (LL_WIDTH)
  ) u_seg_accum (
    .clk       (clk),
    .nrst      (nrst),
    .i_valid   (sample_valid),
    .i_samples (samples),
    .o_done    (w_done),
    .o_raw_ll  (w_raw_ll)
  );

  always_comb begin
    for (int c = 0; c < NUM_CHS; c++) begin
      w_shifted[c] = w_raw_ll[c] >> LL_SHIFT;
      w_level[c]   = (w_shifted[c] > LL_WIDTH'(NUM_LL - 1)) ? LVL_W'(NUM_LL - 1)
                                                            : w_shifted[c][LVL_W-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Encoder FSM, bundle counters and output registers
  // --------------------------------------------------------------------------
  enc_state_e            r_state;
  logic [CH_W-1:0]       r_ch;
  logic [LVL_W-1:0]      r_level [NUM_CHS];
  logic [NUM_CHS-1:0]    r_mask;
  logic [CNT_W-1:0]      r_active;
  logic [CNT_W-1:0]      r_cnt   [DIMENSIONS];
  logic                  r_window_valid;
  logic [DIMENSIONS-1:0] r_window_hv;
  logic                  r_busy;
  logic                  r_overrun;

  logic                  w_accept;
  logic                  w_start;
  logic                  w_drop;
  logic [DIMENSIONS-1:0] w_bound;
  logic [DIMENSIONS-1:0] w_maj;

  assign w_accept = (r_state == ST_OUT) && r_window_valid && window_ready;
  // A completion coinciding with acceptance takes the freed encoder.
  assign w_start  = w_done && ((r_state == ST_IDLE) || w_accept);
  assign w_drop   = w_done && !w_start;

  assign w_bound  = w_ch_hv[r_ch] ^ w_lvl_hv[r_level[r_ch]];

  // Strict majority; ties and an empty mask both give 0.
  always_comb begin
    for (int i = 0; i < DIMENSIONS; i++) begin
      w_maj[i] = ({r_cnt[i], 1'b0} > {1'b0, r_active});
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state        <= ST_IDLE;
      r_ch           <= '0;
      r_mask         <= '0;
      r_active       <= '0;
      r_window_valid <= 1'b0;
      r_window_hv    <= '0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
      for (int c = 0; c < NUM_CHS; c++) begin
        r_level[c] <= '0;
      end
      for (int i = 0; i < DIMENSIONS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      // A set wins over a simultaneous clear.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clear_overrun) begin
        r_overrun <= 1'b0;
      end

      if (w_start) begin
        r_state        <= ST_ENC;
        r_ch           <= '0;
        r_level        <= w_level;
        r_mask         <= ch_mask;
        r_active       <= popcnt(ch_mask);
        r_busy         <= 1'b1;
        r_window_valid <= 1'b0;
        for (int i = 0; i < DIMENSIONS; i++) begin
          r_cnt[i] <= '0;
        end
      end else begin
        case (r_state)
          ST_ENC: begin
            if (r_mask[r_ch]) begin
              for (int i = 0; i < DIMENSIONS; i++) begin
                r_cnt[i] <= r_cnt[i] + CNT_W'(w_bound[i]);
              end
            end
            if (r_ch == CH_W'(NUM_CHS - 1)) begin
              r_state <= ST_MAJ;
            end else begin
              r_ch <= r_ch + CH_W'(1);
            end
          end
          ST_MAJ: begin
            r_window_hv    <= w_maj;
            r_window_valid <= 1'b1;
            r_state        <= ST_OUT;
          end
          ST_OUT: begin
            if (w_accept) begin
              r_window_valid <= 1'b0;
              r_busy         <= 1'b0;
              r_state        <= ST_IDLE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign window_valid = r_window_valid;
  assign window_hv    = r_window_hv;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule
`default_nettype wire
